time_of_day_counter: RTL and testbench
======================================

Name: time_of_day_counter

Overview:
Wall-clock time-of-day counter driven by the one-cycle-per-second tick from the seconds timer. Keeps hours, minutes and seconds in binary and emits rollover strobes. Accepts a valid/ready time-set transaction with range checking. Sits between the timer and the display/control logic of the board design.

Parameters:
HOURS_MAX, 23, last valid hour value; hours wrap from HOURS_MAX to 0 (legal range 1..31).

Ports:
clk  in  1  system clock
async_nreset  in  1  asynchronous active-low reset
tick  in  1  one-cycle strobe, one per elapsed second
hold  in  1  level; 1 freezes counting, ticks are discarded
set_valid  in  1  set request valid
set_ready  out  1  set request accepted when set_valid & set_ready
set_hours  in  5  requested hours
set_minutes  in  6  requested minutes
set_seconds  in  6  requested seconds
set_error  out  1  one-cycle pulse, accepted set was out of range
hours  out  5  current hours
minutes  out  6  current minutes
seconds  out  6  current seconds
minute_elapsed  out  1  one-cycle pulse when seconds wrap 59->0
hour_elapsed  out  1  one-cycle pulse when minutes wrap 59->0
day_elapsed  out  1  one-cycle pulse when hours wrap HOURS_MAX->0

Behaviour:
- Reset (async, active-low): hours/minutes/seconds = 0; set_ready = 0; all pulses = 0; FSM = IDLE. Mid-operation reset aborts any pending set; the time is cleared.
- FSM states:
  - IDLE: set_ready=1. On set_valid, capture set_* into shadow registers and go to CHECK.
  - CHECK: set_ready=0. Range check: hours<=HOURS_MAX, minutes<=59, seconds<=59.
    - Pass: load time from shadow at the end of this cycle, go to IDLE.
    - Fail: set_error=1 for the cycle after CHECK, time unchanged, go to IDLE.
- Set latency: time outputs show the new value 2 cycles after the accepting edge. set_ready returns high the cycle after CHECK.
- Counting: on tick=1 with hold=0 and no load in the same cycle:
  - seconds increments.
  - At 59, seconds -> 0 and minutes increments; same wrap rule cascades minutes->hours and hours (HOURS_MAX)->0.
- Strobes: registered, asserted in the same cycle the new wrapped value first appears on the outputs, one cycle wide. A 23:59:59 -> 00:00:00 tick asserts minute_elapsed, hour_elapsed and day_elapsed together.
- Simultaneous events:
  - Load in CHECK coincides with tick: load wins, tick discarded, no strobes.
  - Tick while in IDLE/CHECK without a load: counted normally.
  - hold=1: ticks dropped, no strobes; set transactions still processed.
- Outputs are registered; no combinational path from inputs to outputs except set_ready (a function of FSM state only).
- Counters never hold illegal values: only range-checked loads and wraps write them.

Optional Feature:
TIME_OF_DAY_ALARM_EN.
- Defined: adds inputs alarm_hours[5], alarm_minutes[6], alarm_enable, alarm_ack, and output alarm_pending.
  - alarm_pending sets the cycle the time becomes alarm_hours:alarm_minutes:00 via a tick while alarm_enable=1. A load never triggers it.
  - It stays high until alarm_ack=1, which clears it on the next edge. If ack and a new trigger coincide, the trigger wins.
  - Reset value 0.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then 61 ticks (spacing 3 cycles) -> 00:01:01; minute_elapsed pulsed exactly once, on the 60th tick; no other strobes.
- Set 23:59:58 (valid), then 2 ticks -> 00:00:00 after the 2nd tick; minute/hour/day_elapsed all high in the same single cycle; set_error never asserted.
- Set 24:00:00 with HOURS_MAX=23 -> set_error one-cycle pulse 2 cycles after acceptance; time unchanged; set_ready back to 1 after CHECK.
- Assert tick in the CHECK cycle of a valid set 12:34:56 -> outputs read 12:34:56 with no increment and no strobes; the next tick gives 12:34:57.
- hold=1 for 10 ticks, then hold=0 and 1 tick -> seconds advanced by 1 only.
- Reset asserted mid-count at 05:06:07 and during CHECK -> all outputs 0 immediately (asynchronous), set_ready=0 while in reset, set_ready=1 the first cycle after release, pending set dropped.

Source files
------------

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: binary h:m:s advanced by a 1 Hz tick, with rollover strobes and a range-checked set port.
// Optional alarm logic is compiled in with TIME_OF_DAY_ALARM_EN.
module time_of_day_counter #(
    parameter int HOURS_MAX = 23
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic       tick,
    input  logic       hold,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic       set_error,
`ifdef TIME_OF_DAY_ALARM_EN
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_enable,
    input  logic       alarm_ack,
    output logic       alarm_pending,
`endif
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       minute_elapsed,
    output logic       hour_elapsed,
    output logic       day_elapsed
);

    localparam logic [4:0] HMAX = 5'(HOURS_MAX);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t     state_q, state_d;
    logic       armed;
    logic [4:0] sh_hours;
    logic [5:0] sh_minutes, sh_seconds;
    logic       capture, load, err_d, range_ok;
    logic       sec_wrap, min_wrap, hr_wrap, count;
    logic [4:0] hr_nxt;
    logic [5:0] min_nxt, sec_nxt;

    // armed keeps set_ready low while in reset and until the first edge after release
    assign set_ready = armed && (state_q == IDLE);
    assign range_ok  = (sh_hours <= HMAX) && (sh_minutes <= 6'd59) && (sh_seconds <= 6'd59);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        load    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (set_valid && set_ready) begin
                capture = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                load    = range_ok;
                err_d   = !range_ok;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sec_wrap = (seconds == 6'd59);
        min_wrap = (minutes == 6'd59);
        hr_wrap  = (hours == HMAX);
        sec_nxt  = sec_wrap ? 6'd0 : seconds + 6'd1;
        min_nxt  = !sec_wrap ? minutes : (min_wrap ? 6'd0 : minutes + 6'd1);
        hr_nxt   = !(sec_wrap && min_wrap) ? hours : (hr_wrap ? 5'd0 : hours + 5'd1);
        count    = tick && !hold && !load;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q        <= IDLE;
            armed          <= 1'b0;
            sh_hours       <= '0;
            sh_minutes     <= '0;
            sh_seconds     <= '0;
            hours          <= '0;
            minutes        <= '0;
            seconds        <= '0;
            set_error      <= 1'b0;
            minute_elapsed <= 1'b0;
            hour_elapsed   <= 1'b0;
            day_elapsed    <= 1'b0;
        end else begin
            state_q        <= state_d;
            armed          <= 1'b1;
            set_error      <= err_d;
            minute_elapsed <= count && sec_wrap;
            hour_elapsed   <= count && sec_wrap && min_wrap;
            day_elapsed    <= count && sec_wrap && min_wrap && hr_wrap;
            if (capture) begin
                sh_hours   <= set_hours;
                sh_minutes <= set_minutes;
                sh_seconds <= set_seconds;
            end
            if (load) begin
                hours   <= sh_hours;
                minutes <= sh_minutes;
                seconds <= sh_seconds;
            end else if (count) begin
                hours   <= hr_nxt;
                minutes <= min_nxt;
                seconds <= sec_nxt;
            end
        end
    end

`ifdef TIME_OF_DAY_ALARM_EN
    logic alarm_hit;
    assign alarm_hit = count && alarm_enable && (hr_nxt == alarm_hours)
                       && (min_nxt == alarm_minutes) && (sec_nxt == 6'd0);

    // a trigger coinciding with ack keeps the alarm pending
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset)  alarm_pending <= 1'b0;
        else if (alarm_hit) alarm_pending <= 1'b1;
        else if (alarm_ack) alarm_pending <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomised and directed bench for time_of_day_counter; time is modelled as seconds-of-day.
module tb_time_of_day_counter;

    localparam int HM  = 23;
    localparam int DAY = (HM + 1) * 3600;

    logic       clk = 1'b0;
    logic       async_nreset = 1'b0;
    logic       tick = 1'b0, hold = 1'b0, set_valid = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0, set_seconds = '0;
    logic       set_ready, set_error;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       minute_elapsed, hour_elapsed, day_elapsed;

    time_of_day_counter #(.HOURS_MAX(HM)) dut (
        .clk(clk), .async_nreset(async_nreset), .tick(tick), .hold(hold),
        .set_valid(set_valid), .set_ready(set_ready), .set_hours(set_hours),
        .set_minutes(set_minutes), .set_seconds(set_seconds), .set_error(set_error),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .minute_elapsed(minute_elapsed), .hour_elapsed(hour_elapsed), .day_elapsed(day_elapsed)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_min = 0, n_hr = 0, n_day = 0, n_err = 0;

    // reference model: wall time as seconds since midnight plus the set handshake
    int t = 0;
    bit m_check = 0, m_armed = 0;
    int sh_h = 0, sh_m = 0, sh_s = 0;
    bit e_min = 0, e_hr = 0, e_day = 0, e_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int dut_time();
        return hms(int'(hours), int'(minutes), int'(seconds));
    endfunction

    task automatic step(input logic tk, input logic hd, input logic vl,
                        input int h, input int m, input int s);
        bit ok, rdy;
        @(negedge clk);
        tick = tk; hold = hd; set_valid = vl;
        set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        @(posedge clk);
        rdy = m_armed && !m_check;
        ok  = (sh_h <= HM) && (sh_m <= 59) && (sh_s <= 59);
        e_min = 0; e_hr = 0; e_day = 0; e_err = 0;
        if (m_check && ok) t = hms(sh_h, sh_m, sh_s);
        else begin
            if (m_check) e_err = 1;
            if (tk && !hd) begin
                t = (t + 1) % DAY;
                e_min = (t % 60) == 0;
                e_hr  = (t % 3600) == 0;
                e_day = t == 0;
            end
        end
        if (m_check) m_check = 0;
        else if (rdy && vl) begin
            m_check = 1; sh_h = h; sh_m = m; sh_s = s;
        end
        m_armed = 1;
        #1;
        chk("time", dut_time(), t);
        chk("strobes", int'({minute_elapsed, hour_elapsed, day_elapsed}),
            int'({e_min, e_hr, e_day}));
        chk("set_error", int'(set_error), int'(e_err));
        chk("set_ready", int'(set_ready), int'(m_armed && !m_check));
        n_min += int'(minute_elapsed); n_hr += int'(hour_elapsed);
        n_day += int'(day_elapsed);    n_err += int'(set_error);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // accept a set in IDLE, optionally ticking during the CHECK cycle
    task automatic do_set(input int h, input int m, input int s, input logic tk_check);
        chk("set_ready_before_set", int'(set_ready), 1);
        step(0, 0, 1, h, m, s);
        step(tk_check, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_mid();
        @(negedge clk);
        tick = 0; hold = 0; set_valid = 0;
        #2 async_nreset = 1'b0;
        #1;
        chk("rst_async_out", int'({hours, minutes, seconds, set_error, minute_elapsed,
                                   hour_elapsed, day_elapsed}), 0);
        chk("rst_ready", int'(set_ready), 0);
        t = 0; m_check = 0; m_armed = 0; sh_h = 0; sh_m = 0; sh_s = 0;
        @(posedge clk);
        #1;
        chk("rst_hold_out", dut_time(), 0);
        chk("rst_hold_ready", int'(set_ready), 0);
        @(negedge clk);
        async_nreset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("ready_after_release", int'(set_ready), 1);
    endtask

    initial begin
        #1;
        chk("reset_time", dut_time(), 0);
        chk("reset_ready", int'(set_ready), 0);
        chk("reset_pulses", int'({set_error, minute_elapsed, hour_elapsed, day_elapsed}), 0);
        #13 async_nreset = 1'b1;
        idle(1);

        // 61 ticks from midnight
        n_min = 0; n_hr = 0; n_day = 0;
        for (int i = 0; i < 61; i++) begin
            step(1, 0, 0, 0, 0, 0);
            idle(2);
        end
        chk("t1_time", dut_time(), 61);
        chk("t1_min_cnt", n_min, 1);
        chk("t1_other", n_hr + n_day, 0);

        // day rollover
        n_min = 0; n_hr = 0; n_day = 0; n_err = 0;
        do_set(23, 59, 58, 0);
        idle(1);
        chk("t2_loaded", dut_time(), hms(23, 59, 58));
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_midnight", dut_time(), 0);
        chk("t2_all_strobes", int'({minute_elapsed, hour_elapsed, day_elapsed}), 7);
        idle(1);
        chk("t2_counts", n_min * 100 + n_hr * 10 + n_day, 111);
        chk("t2_no_err", n_err, 0);

        // out of range hour
        n_err = 0;
        do_set(24, 0, 0, 0);
        idle(1);
        chk("t3_err_cnt", n_err, 1);
        chk("t3_time", dut_time(), 0);
        chk("t3_ready", int'(set_ready), 1);

        // tick coinciding with load is discarded
        n_min = 0;
        do_set(12, 34, 56, 1);
        chk("t4_load_wins", dut_time(), hms(12, 34, 56));
        step(1, 0, 0, 0, 0, 0);
        chk("t4_next", dut_time(), hms(12, 34, 57));

        // hold drops ticks
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
        chk("t5_held", dut_time(), hms(12, 34, 57));
        step(1, 0, 0, 0, 0, 0);
        chk("t5_one", dut_time(), hms(12, 34, 58));

        // reset mid-count and during CHECK
        do_set(5, 6, 7, 0);
        idle(1);
        rst_mid();
        step(0, 0, 1, 1, 2, 3);
        rst_mid();
        idle(2);
        chk("t6_dropped", dut_time(), 0);

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            int h, m, s;
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
            end else begin
                h = $urandom_range(0, HM); m = $urandom_range(0, 59);
                s = $urandom_range(50, 59);
            end
            step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 9) == 0), h, m, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
